// File: rtl/key_event_gen_if.sv
// Key event bundle: debounced key level in, event pulses,
// levels and the press counter out.
interface key_event_gen_if;
  logic       key_in;
  logic       press_pulse;
  logic       release_pulse;
  logic       repeat_pulse;
  logic       step_pulse;
  logic       long_press;
  logic       held;
  logic [7:0] press_count;

  modport master (
    output key_in,
    input  press_pulse, release_pulse, repeat_pulse,
    input  step_pulse, long_press, held, press_count
  );

  modport slave (
    input  key_in,
    output press_pulse, release_pulse, repeat_pulse,
    output step_pulse, long_press, held, press_count
  );
endinterface

// File: rtl/key_event_gen.sv
// Key event generator: turns a clean key level into press, release,
// long-press and auto-repeat strobes plus an 8-bit press counter.
// Ports: clk, RESET (sync, active low), bus (key_event_gen_if.slave).
module key_event_gen #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 26
) (
  input logic            clk,
  input logic            RESET,
  key_event_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ARM,
    IDLE,
    PRESSED,
    LONG
  } state_t;

  localparam logic [CNT_W-1:0] LONG_C = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] REP_C  = CNT_W'(REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_q, state_d;
  logic             key_q;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rpt_q, rpt_d;
  logic             step_q, step_d;
  logic             long_q, long_d;
  logic             held_q, held_d;
  logic             rise;

  assign rise = bus.key_in & ~key_q;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q <= ARM;
      key_q   <= 1'b1;
      hold_q  <= '0;
      rep_q   <= '0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      rpt_q   <= 1'b0;
      step_q  <= 1'b0;
      long_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= bus.key_in;
      hold_q  <= hold_d;
      rep_q   <= rep_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rpt_q   <= rpt_d;
      step_q  <= step_d;
      long_q  <= long_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rpt_d   = 1'b0;
    unique case (state_q)
      ARM: begin
        if (!bus.key_in) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          cnt_d   = cnt_q + 8'd1;
          hold_d  = ONE_C;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (!bus.key_in) begin
          rel_d   = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (hold_q == LONG_C) begin
          // counter has covered the full hold window
          rpt_d   = 1'b1;
          rep_d   = ONE_C;
          state_d = LONG;
        end else begin
          hold_d = hold_q + ONE_C;
        end
      end
      LONG: begin
        // release outranks a repeat due on the same edge
        if (!bus.key_in) begin
          rel_d   = 1'b1;
          hold_d  = '0;
          rep_d   = '0;
          state_d = IDLE;
        end else if (rep_q == REP_C) begin
          rpt_d = 1'b1;
          rep_d = ONE_C;
        end else begin
          rep_d = rep_q + ONE_C;
        end
      end
      default: state_d = ARM;
    endcase
    step_d = press_d | rpt_d;
    long_d = (state_d == LONG);
    held_d = (state_d == PRESSED) || (state_d == LONG);
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;
  assign bus.repeat_pulse  = rpt_q;
  assign bus.step_pulse    = step_q;
  assign bus.long_press    = long_q;
  assign bus.held          = held_q;
  assign bus.press_count   = cnt_q;

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Sits directly downstream of the key debouncer; consumes its clean, clk-synchronous level and turns it into single-cycle events for the single-cycle CPU board logic.
- Events: press, release, long-press and auto-repeat step pulses, used as the CPU single-step / clock-advance strobe.
- Keeps an 8-bit wrapping press counter for display and debug.

Parameters:
- LONG_CYCLES, 25000000, hold length in clk cycles before long-press is declared. Must be >= 2.
- REPEAT_CYCLES, 5000000, period in clk cycles of auto-repeat pulses while long-press is active. Must be >= 1.
- CNT_W, 26, width of the internal hold/repeat counters. Must hold max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-low reset (RESET==0 at a clk rising edge resets).
- key_in  input  1  debounced key level from the debouncer, already synchronous to clk; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on accepted press.
- release_pulse  output  1  one-cycle pulse on release after an accepted press.
- repeat_pulse  output  1  one-cycle auto-repeat pulse.
- step_pulse  output  1  press_pulse OR repeat_pulse; the CPU step strobe.
- long_press  output  1  level; high while the key is held beyond LONG_CYCLES.
- held  output  1  level; high while in the PRESSED or LONG state.
- press_count  output  8  count of accepted presses, wraps 255->0.

Behaviour:
- All outputs are registered; no combinational path from key_in to any output.
- Internal register key_q holds key_in sampled at the previous edge. A rise is key_in=1 and key_q=0 at an edge; a fall is key_in=0 and key_q=1.
- Reset (RESET==0 at an edge):
  - All outputs go to 0; press_count goes to 0.
  - Counters clear; key_q goes to 1.
  - State goes to ARM.
  - Reset takes priority over every event, including mid-hold and mid-pulse.
- ARM state:
  - Ignores key_in==1.
  - Moves to IDLE at the first edge where key_in==0.
  - Prevents a spurious press when the key is held through reset, or when the debouncer output is still unknown after power-up.
- IDLE state:
  - On a rise at edge k: press_pulse=1 and step_pulse=1 for the cycle after edge k.
  - press_count increments at edge k (modulo 256).
  - hold_cnt goes to 1; state goes to PRESSED; held=1.
- PRESSED state:
  - Each edge with key_in==1: hold_cnt increments.
  - At the edge where hold_cnt would reach LONG_CYCLES (edge k+LONG_CYCLES): state goes to LONG, long_press=1, repeat_pulse=1 and step_pulse=1 for one cycle, rep_cnt goes to 1.
- LONG state:
  - Each edge with key_in==1: rep_cnt increments.
  - When rep_cnt would reach REPEAT_CYCLES: repeat_pulse=1 and step_pulse=1 for one cycle, rep_cnt goes to 1.
  - Repeats therefore fall at edges k+LONG_CYCLES+n*REPEAT_CYCLES.
- Release from PRESSED or LONG (key_in==0 sampled at edge m):
  - release_pulse=1 for the cycle after edge m.
  - long_press=0 and held=0 at edge m; counters clear; state goes to IDLE.
  - If a repeat would also fire at edge m, release wins and no repeat/step pulse is produced.
- Minimum press: 1 high sample gives press at edge k and release at edge k+1. Back-to-back press after release needs one low sample, which is already satisfied by the fall.
- Pulses are exactly one cycle wide; press_pulse and repeat_pulse are never high together.
- Counters saturate/clear as described; they never wrap while the key is held.

Test Plan:
All scenarios use LONG_CYCLES=8, REPEAT_CYCLES=4, RESET released at edge 2, key_in=0 unless stated.
1. key_in=1 sampled at edges 10-12, 0 at 13 -> press_pulse and step_pulse high only after edge 10; release_pulse only after edge 13; press_count=1; long_press never high.
2. key_in=1 held from before edge 0 through edge 20, then 0, then 1 at edge 25 -> no pulses before edge 25; press_pulse after edge 25; press_count=1.
3. key_in=1 at edges 10-29, 0 at 30 -> long_press high from edge 18 to edge 30; repeat_pulse after edges 18, 22 and 26 only (the edge-30 repeat is suppressed); release after 30; total step_pulse count=4.
4. 257 presses of 2 cycles each, separated by 2 low cycles -> press_count reads 255 after press 255, 0 after press 256, 1 after press 257.
5. Hold from edge 10; RESET=0 at edge 20; RESET=1 from edge 21 with key still 1 until edge 24 -> all outputs 0 after edge 20; no press_pulse until a new rise after key_in returns to 0.
6. key_in=1 sampled only at edge 10 -> press_pulse after edge 10, release_pulse after edge 11, no other pulses.
